rr_arb16: RTL and testbench

// - Round-robin arbiter sharing one n-bit output channel among 16 requesters.
// - Picks a winner, captures its data through a _mux16 and holds it on a valid/ready output until the sink accepts it.
// - Returns a one-cycle ack to the winner.
// - Sits between requesting units (register-file ports, bus masters) and one shared sink.

---
 rtl/rr_arb16_if.sv | 33 +++
 rtl/rr_arb16.sv | 105 ++++++++++
 tb/tb_rr_arb16.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/rr_arb16_if.sv
// Handshake bundle between 16 requesters, the round-robin arbiter and one shared sink.
// master = arbiter side, slave = requester/sink environment side.
interface rr_arb16_if #(
    parameter int unsigned BitWidth = 8
);
    logic [15:0]            req;
    logic [16*BitWidth-1:0] in_data;
    logic [15:0]            ack;
    logic                   out_valid;
    logic                   out_ready;
    logic [BitWidth-1:0]    out_data;
    logic [3:0]             gnt_id;

    modport master (
        input  req,
        input  in_data,
        input  out_ready,
        output ack,
        output out_valid,
        output out_data,
        output gnt_id
    );

    modport slave (
        output req,
        output in_data,
        output out_ready,
        input  ack,
        input  out_valid,
        input  out_data,
        input  gnt_id
    );
endinterface

// File: rtl/rr_arb16.sv
// Round-robin arbiter: 16 requesters share one registered valid/ready output channel.
// Back-to-back grants are possible; the just-served requester is masked in its own ack cycle.
module rr_arb16 #(
    parameter int unsigned BitWidth = 8
) (
    input logic         clk,
    input logic         rst_n,
    rr_arb16_if.master  bus
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e              state_q, state_d;
    logic [3:0]          ptr_q, ptr_d;
    logic [3:0]          gnt_q, gnt_d;
    logic [BitWidth-1:0] data_q, data_d;

    logic                handshake;
    logic [3:0]          search_base;
    logic [15:0]         elig;
    logic [31:0]         rot;
    logic [3:0]          win_off;
    logic [3:0]          win;
    logic                win_found;
    logic [BitWidth-1:0] win_data;

    function automatic logic [BitWidth-1:0] mux16(input logic [16*BitWidth-1:0] d,
                                                  input logic [3:0]            sel);
        logic [BitWidth-1:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (sel == i[3:0]) r = d[i*BitWidth +: BitWidth];
        end
        return r;
    endfunction

    // Winner search: rotate eligible requests so offset 0 is the search base.
    always_comb begin
        handshake   = (state_q == StBusy) && bus.out_ready;
        search_base = handshake ? gnt_q + 4'd1 : ptr_q;
        elig        = bus.req;
        if (handshake) elig[gnt_q] = 1'b0;
        rot         = {elig, elig} >> search_base;
        win_off     = 4'd0;
        win_found   = 1'b0;
        for (int k = 15; k >= 0; k--) begin
            if (rot[k]) begin
                win_off   = k[3:0];
                win_found = 1'b1;
            end
        end
        win      = search_base + win_off;
        win_data = mux16(bus.in_data, win);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= 4'd0;
            gnt_q   <= 4'd0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    gnt_d   = win;
                    data_d  = win_data;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (bus.out_ready) begin
                    ptr_d = gnt_q + 4'd1;
                    if (win_found) begin
                        gnt_d  = win;
                        data_d = win_data;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.out_valid = (state_q == StBusy);
        bus.out_data  = data_q;
        bus.gnt_id    = gnt_q;
        bus.ack       = handshake ? (16'd1 << gnt_q) : 16'd0;
    end

endmodule

// File: tb/tb_rr_arb16.sv
// Bench for rr_arb16: directed scenarios plus randomized traffic against a rule-level model.
module tb_rr_arb16;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    rr_arb16_if #(.BitWidth(W)) bus ();

    rr_arb16 #(.BitWidth(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic         m_valid;
    logic [W-1:0] m_data;
    logic [3:0]   m_gnt;
    logic [3:0]   m_ptr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_gnt   = 4'd0;
        m_ptr   = 4'd0;
    endtask

    task automatic compare_all(input string tag);
        logic [15:0] exp_ack;
        exp_ack = (m_valid && bus.out_ready) ? (16'd1 << m_gnt) : 16'd0;
        check_eq({tag, ".valid"}, 32'(bus.out_valid), 32'(m_valid));
        check_eq({tag, ".data"},  32'(bus.out_data),  32'(m_data));
        check_eq({tag, ".gnt"},   32'(bus.gnt_id),    32'(m_gnt));
        check_eq({tag, ".ack"},   32'(bus.ack),       32'(exp_ack));
    endtask

    // Rules: a handshake moves the pointer past the winner and masks it; the first
    // requesting index at or after the pointer (mod 16) wins whenever the output is free.
    task automatic model_clock();
        logic hs;
        int   win;
        hs = m_valid && bus.out_ready;
        if (hs) m_ptr = m_gnt + 4'd1;
        if (!m_valid || hs) begin
            win = -1;
            for (int off = 0; off < 16; off++) begin
                int i = (int'(m_ptr) + off) % 16;
                if (win < 0 && bus.req[i] && !(hs && i == int'(m_gnt))) win = i;
            end
            if (win >= 0) begin
                m_gnt   = 4'(win);
                m_data  = bus.in_data[win*W +: W];
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        compare_all(tag);
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("rst.valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [W-1:0] saved;

    initial begin
        rst_n         = 1'b0;
        bus.req       = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        model_reset();
        #12;
        compare_all("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) step("idle");

        // Single requester from reset: word appears after the next edge and is acked at once.
        bus.req           = 16'h0001;
        bus.in_data[7:0]  = 8'hA5;
        bus.out_ready     = 1'b1;
        step("first");
        check_eq("first.data", 32'(bus.out_data), 32'h00A5);
        @(negedge clk);
        check_eq("first.ack", 32'(bus.ack), 32'h0001);
        model_clock();
        @(posedge clk);
        #1;
        bus.req = '0;
        step("first.idle");

        // All requesting: strict rotation, one grant per cycle.
        do_reset();
        bus.req = 16'hFFFF;
        for (int i = 0; i < 16; i++) bus.in_data[i*W +: W] = W'(i);
        bus.out_ready = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            step("rot");
            check_eq("rot.gnt",  32'(bus.gnt_id),   32'(k % 16));
            check_eq("rot.data", 32'(bus.out_data), 32'(k % 16));
        end

        // Wrap: serve 14 so the pointer lands on 15, then 15 and 0 compete.
        do_reset();
        bus.req = 16'h4000;
        step("wrap.load14");
        bus.req = 16'h8001;
        step("wrap.hs14");
        check_eq("wrap.gnt15", 32'(bus.gnt_id), 32'd15);
        step("wrap.hs15");
        check_eq("wrap.gnt0", 32'(bus.gnt_id), 32'd0);
        bus.req = '0;
        step("wrap.drain");

        // Stall: output frozen while in_data churns, then the original word is acked.
        do_reset();
        bus.req       = 16'h0010;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) bus.in_data[i*W +: W] = W'($urandom);
        saved = bus.in_data[4*W +: W];
        step("stall.load");
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < 16; i++) bus.in_data[i*W +: W] = W'($urandom);
            step("stall");
            check_eq("stall.data", 32'(bus.out_data), 32'(saved));
            check_eq("stall.gnt",  32'(bus.gnt_id),   32'd4);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_eq("stall.ack", 32'(bus.ack), 32'h0010);
        check_eq("stall.final", 32'(bus.out_data), 32'(saved));
        model_clock();
        @(posedge clk);
        #1;
        bus.req = '0;
        step("stall.idle");

        // Reset while busy: valid drops at once, no ack, pointer returns to 0.
        do_reset();
        bus.req = 16'h0100;
        step("rmid.load8");
        step("rmid.hs8");
        bus.req       = 16'h0200;
        bus.out_ready = 1'b0;
        step("rmid.load9");
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        #1;
        check_eq("rmid.valid", 32'(bus.out_valid), 32'd0);
        check_eq("rmid.ack",   32'(bus.ack),       32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        bus.req = 16'h0101;
        step("rmid.rearb");
        check_eq("rmid.gnt0", 32'(bus.gnt_id), 32'd0);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                bus.req = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom & $urandom);
                for (int i = 0; i < 16; i++) bus.in_data[i*W +: W] = W'($urandom);
                bus.out_ready = ($urandom_range(0, 3) != 0);
                step("rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
